// File: rtl/mimm_scrub_pkg.sv
// mimm_scrub_pkg: state encoding and pass-mode constants for the RAM init/scrub engine.
package mimm_scrub_pkg;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD, S_CHK, S_FIX, S_DONE} state_e;
  localparam logic MODE_INIT = 1'b0;
  localparam logic MODE_SCRUB = 1'b1;
endpackage

// File: rtl/mimm_scrub_if.sv
// mimm_scrub_if: control, status and RAM-port signals of the scrub engine.
interface mimm_scrub_if #(parameter int AW = 8, parameter int DW = 64);
  logic start, mode, fixen, abort, gnt;
  logic req, busy, done;
  logic [AW:0] errcnt;
  logic [AW-1:0] erraddr, waddr, raddr;
  logic wr, rd, parityerr;
  logic [DW-1:0] wdata, rdata;
  modport master (output start, mode, fixen, abort, gnt, rdata, parityerr,
                  input req, busy, done, errcnt, erraddr, waddr, wr, wdata, raddr, rd);
  modport slave (input start, mode, fixen, abort, gnt, rdata, parityerr,
                 output req, busy, done, errcnt, erraddr, waddr, wr, wdata, raddr, rd);
endinterface

// File: rtl/mimm_dpram.sv
// mimm_dpram: dual-port RAM with one parity bit per word; side port preloads data or corrupt parity.
module mimm_dpram #(parameter int AW = 8, parameter int DW = 64) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_data,
  input  logic          ext_bad,
  output logic [DW-1:0] rdata,
  output logic          perr
);
  logic [DW-1:0] mem [2**AW];
  logic par [2**AW];
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
      par[waddr] <= ^wdata;
    end else if (ext_we) begin
      mem[ext_addr] <= ext_data;
      par[ext_addr] <= (^ext_data) ^ ext_bad;
    end
    if (re) begin
      rdata <= mem[raddr];
      perr <= par[raddr] != (^mem[raddr]);
    end
  end
endmodule

// File: rtl/mimm_scrub.sv
// mimm_scrub: walks a RAM once per start, either zero-filling it or parity-checking
// (and optionally rewriting) every word, counting errors and recording the first one.
module mimm_scrub
  import mimm_scrub_pkg::*;
#(parameter int AW = 8, parameter int DW = 64, parameter int DCNT = 2**AW) (
  input logic clk,
  input logic reset,
  mimm_scrub_if.slave bus
);
  state_e state_q, state_d, adv_state;
  logic [AW-1:0] cnt_q, cnt_d, erraddr_q, erraddr_d, adv_cnt;
  logic [AW:0] errcnt_q, errcnt_d;
  logic [DW-1:0] data_q, data_d;
  logic fixen_q, fixen_d, last, act, fix;
  assign last = cnt_q == AW'(DCNT - 1);
  assign act = bus.gnt && !bus.abort;
  assign fix = bus.parityerr && fixen_q;
  assign adv_cnt = last ? cnt_q : cnt_q + 1'b1;
  assign adv_state = last ? S_DONE : (state_q == S_INIT ? S_INIT : S_RD);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    errcnt_d = errcnt_q;
    erraddr_d = erraddr_q;
    data_d = data_q;
    fixen_d = fixen_q;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = bus.mode == MODE_SCRUB ? S_RD : S_INIT;
        cnt_d = '0;
        errcnt_d = '0;
        erraddr_d = '0;
        fixen_d = bus.fixen;
      end
    end else if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_INIT, S_FIX: begin
          state_d = bus.gnt ? adv_state : state_q;
          cnt_d = bus.gnt ? adv_cnt : cnt_q;
        end
        S_RD: state_d = bus.gnt ? S_CHK : S_RD;
        S_CHK: begin
          data_d = bus.rdata;
          errcnt_d = bus.parityerr && !(&errcnt_q) ? errcnt_q + 1'b1 : errcnt_q;
          erraddr_d = bus.parityerr && errcnt_q == '0 ? cnt_q : erraddr_q;
          state_d = fix ? S_FIX : adv_state;
          cnt_d = fix ? cnt_q : adv_cnt;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      errcnt_q <= '0;
      erraddr_q <= '0;
      data_q <= '0;
      fixen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      errcnt_q <= errcnt_d;
      erraddr_q <= erraddr_d;
      data_q <= data_d;
      fixen_q <= fixen_d;
    end
  end
  assign bus.busy = state_q != S_IDLE;
  assign bus.req = bus.busy;
  assign bus.done = state_q == S_DONE;
  assign bus.rd = state_q == S_RD && act;
  assign bus.wr = (state_q == S_INIT || state_q == S_FIX) && act;
  assign bus.waddr = cnt_q;
  assign bus.raddr = cnt_q;
  assign bus.wdata = state_q == S_FIX ? data_q : '0;
  assign bus.errcnt = errcnt_q;
  assign bus.erraddr = erraddr_q;
endmodule

// File: tb/tb_mimm_scrub.sv
// tb_mimm_scrub: random RAM images checked against a per-pass reference model via scoreboard queues.
module tb_mimm_scrub;
  import mimm_scrub_pkg::*;
  localparam int AW = 8, DW = 64, N = 256;
  logic clk = 0, reset = 1;
  logic ext_we = 0, ext_bad = 0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_data = '0;
  int vectors = 0, fails = 0, cyc = 0, start_cyc = 0;
  typedef struct {int errc; int erra; int cycles; bit timed;} pass_t;
  pass_t pq[$];
  int wqa[$], rq[$];
  logic [DW-1:0] wqd[$];
  logic [DW-1:0] img [N];
  bit bad [N];
  mimm_scrub_if #(.AW(AW), .DW(DW)) b();
  mimm_scrub #(.AW(AW), .DW(DW), .DCNT(N)) dut (.clk(clk), .reset(reset), .bus(b));
  mimm_dpram #(.AW(AW), .DW(DW)) u_ram (
    .clk(clk), .we(b.wr), .waddr(b.waddr), .wdata(b.wdata), .re(b.rd), .raddr(b.raddr),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data), .ext_bad(ext_bad),
    .rdata(b.rdata), .perr(b.parityerr));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Expected outcome of a whole pass, derived from the current RAM image.
  function automatic void expect_pass(bit mode, bit fixen, bit timed);
    pass_t p;
    int nfix = 0;
    p.errc = 0;
    p.erra = 0;
    for (int a = 0; a < N; a++) begin
      if (mode == MODE_INIT) begin
        wqa.push_back(a);
        wqd.push_back('0);
      end else begin
        rq.push_back(a);
        if (bad[a]) begin
          if (p.errc == 0) p.erra = a;
          p.errc = p.errc == 2**(AW+1) - 1 ? p.errc : p.errc + 1;
          if (fixen) begin
            wqa.push_back(a);
            wqd.push_back(img[a]);
            nfix++;
          end
        end
      end
    end
    p.cycles = mode == MODE_INIT ? N + 1 : 2 * N + nfix + 1;
    p.timed = timed;
    pq.push_back(p);
  endfunction
  function automatic void flush();
    pq.delete();
    wqa.delete();
    wqd.delete();
    rq.delete();
  endfunction
  always @(negedge clk) begin
    pass_t p;
    int a;
    if (!reset) begin
      if (b.start && !b.busy) start_cyc = cyc;
      vectors++;
      if (((b.rd || b.wr) && !b.gnt) || (b.rd && b.wr) || b.req !== b.busy) begin
        fails++;
        $display("FAIL proto: rd=%b wr=%b gnt=%b req=%b busy=%b", b.rd, b.wr, b.gnt, b.req, b.busy);
      end
      if (b.rd) begin
        if (rq.size() == 0) check("unexpected_rd", {56'd0, b.raddr}, 64'hffff);
        else check("raddr", {56'd0, b.raddr}, rq.pop_front());
      end
      if (b.wr) begin
        if (wqa.size() == 0) check("unexpected_wr", {56'd0, b.waddr}, 64'hffff);
        else begin
          a = wqa.pop_front();
          check("waddr", {56'd0, b.waddr}, a);
          check("wdata", b.wdata, wqd[0]);
          img[a] = wqd.pop_front();
          bad[a] = 0;
        end
      end
      if (b.done) begin
        if (pq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          p = pq.pop_front();
          check("errcnt", b.errcnt, p.errc);
          check("erraddr", b.erraddr, p.erra);
          if (p.timed) check("done_cycle", cyc - start_cyc, p.cycles);
          check("writes_left", wqa.size(), 0);
          check("reads_left", rq.size(), 0);
        end
      end
    end
  end
  task automatic preload(int b1, int b2);
    for (int a = 0; a < N; a++) begin
      ext_we = 1;
      ext_addr = AW'(a);
      ext_data = {$urandom, $urandom};
      ext_bad = a == b1 || a == b2;
      img[a] = ext_data;
      bad[a] = ext_bad;
      tick();
    end
    ext_we = 0;
    ext_bad = 0;
  endtask
  task automatic check_mem(string tag);
    for (int a = 0; a < N; a++) begin
      check({tag, "_mem"}, u_ram.mem[a], img[a]);
      check({tag, "_par"}, {63'd0, u_ram.par[a] != (^u_ram.mem[a])}, {63'd0, bad[a]});
    end
  endtask
  task automatic run(bit mode, bit fixen, bit rand_gnt, bit ghost);
    int n = 0;
    expect_pass(mode, fixen, !rand_gnt);
    b.mode = mode;
    b.fixen = fixen;
    b.start = 1;
    tick();
    b.start = 0;
    while (!b.done && n < 3000) begin
      b.gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      b.start = ghost && n == 40;
      b.mode = ghost && n == 40 ? ~mode : mode;
      tick();
      n++;
    end
    b.start = 0;
    b.gnt = 1;
    if (!b.done) begin
      check("pass_timeout", n, 0);
      flush();
    end
    tick();
  endtask
  task automatic wait_word(int w, string tag);
    int n = 0;
    while (!(b.wr && b.waddr == AW'(w)) && n < 1000) begin
      tick();
      n++;
    end
    if (n == 1000) check({tag, "_timeout"}, n, 0);
  endtask
  task automatic check_zero_outputs(string tag);
    check({tag, "_busy"}, b.busy, 0);
    check({tag, "_req"}, b.req, 0);
    check({tag, "_done"}, b.done, 0);
    check({tag, "_rd"}, b.rd, 0);
    check({tag, "_wr"}, b.wr, 0);
    check({tag, "_errcnt"}, b.errcnt, 0);
    check({tag, "_erraddr"}, b.erraddr, 0);
    check({tag, "_waddr"}, b.waddr, 0);
    check({tag, "_raddr"}, b.raddr, 0);
    check({tag, "_wdata"}, b.wdata, 0);
  endtask
  initial begin
    b.start = 0;
    b.mode = 0;
    b.fixen = 0;
    b.abort = 0;
    b.gnt = 1;
    #2;
    check_zero_outputs("reset");
    tick();
    tick();
    reset = 0;
    tick();
    preload(-1, -1);
    run(MODE_INIT, 0, 0, 0);
    check_mem("init");
    preload(5, 200);
    run(MODE_SCRUB, 0, 0, 1);
    check_mem("scrub_nofix");
    run(MODE_SCRUB, 1, 0, 0);
    check_mem("scrub_fix");
    run(MODE_SCRUB, 0, 0, 0);
    preload(17, 90);
    run(MODE_SCRUB, 1, 1, 0);
    check_mem("scrub_randgnt");
    preload(150, -1);
    expect_pass(MODE_INIT, 0, 0);
    b.mode = MODE_INIT;
    b.start = 1;
    tick();
    b.start = 0;
    wait_word(100, "abort_wait");
    b.abort = 1;
    tick();
    check("abort_busy", b.busy, 0);
    b.abort = 0;
    flush();
    repeat (3) tick();
    check_mem("abort");
    run(MODE_SCRUB, 0, 0, 0);
    preload(-1, -1);
    expect_pass(MODE_INIT, 0, 0);
    b.mode = MODE_INIT;
    b.start = 1;
    tick();
    b.start = 0;
    wait_word(40, "reset_wait");
    reset = 1;
    #1;
    check_zero_outputs("midreset");
    flush();
    tick();
    tick();
    reset = 0;
    repeat (3) tick();
    check_mem("midreset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/mimm_scrub.md
MIMM_SCRUB -- requirements
Module: mimm_scrub

Interface
REQ-001 SHALL have parameter AW, default 8, meaning RAM address width.
REQ-002 SHALL have parameter DW, default 64, meaning RAM data width; a multiple of 8.
REQ-003 SHALL have parameter DCNT, default 2**AW, meaning number of RAM words walked; 1..2**AW.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that launches a pass; ignored while busy.
REQ-007 SHALL have port mode  in  1  sampled at start: 0 = INIT (write zero to all words), 1 = SCRUB (read and parity-check all words).
REQ-008 SHALL have port fixen  in  1  sampled at start: in SCRUB, rewrite each failing word.
REQ-009 SHALL have port abort  in  1  terminates the pass.
REQ-010 SHALL have port gnt  in  1  RAM access grant from the arbiter.
REQ-011 SHALL have port req  out  1  RAM access request; high while busy.
REQ-012 SHALL have port busy  out  1  pass in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse when a pass completes normally.
REQ-014 SHALL have port errcnt  out  AW+1  parity errors in the last or current pass; saturates at all-ones.
REQ-015 SHALL have port erraddr  out  AW  address of the first error in the pass.
REQ-016 SHALL have port waddr, wr, wdata  out  AW, 1, DW  RAM write port.
REQ-017 SHALL have port raddr, rd  out  AW, 1  RAM read port.
REQ-018 SHALL have port rdata, parityerr  in  DW, 1  RAM read data and parity error; both valid the cycle after rd.

Function
REQ-019 SHALL implement states IDLE, INIT, RD, CHK, FIX, DONE.
REQ-020 IDLE->INIT or IDLE->RD on start, chosen by mode; address counter cleared; errcnt and erraddr cleared.
REQ-021 INIT, per word:
- wr=1, wdata=0, waddr=counter in each cycle with gnt=1.
- Counter increments; one word per granted cycle.
- After word DCNT-1, goes to DONE.
REQ-022 RD: rd=1, raddr=counter for exactly one granted cycle, then CHK.
REQ-023 CHK: no RAM access, no gnt needed; samples rdata and parityerr.
- Error with fixen=1: goes to FIX.
- Otherwise: counter increments; goes to RD, or to DONE after word DCNT-1.
REQ-024 FIX: wr=1, waddr=counter, wdata=rdata captured in CHK, in one granted cycle; then advances as in CHK.
REQ-025 On each parity error:
- errcnt increments, saturating.
- erraddr loads the counter only when errcnt was 0.
REQ-026 rd and wr SHALL be asserted only when gnt=1; with gnt=0 the FSM holds state and counter.
REQ-027 rd and wr SHALL never be asserted in the same cycle.
REQ-028 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-029 busy=1 in every state except IDLE; req equals busy.
REQ-030 abort=1 in any busy state: next state IDLE, no done, no RAM access that cycle; errcnt and erraddr keep their values.
REQ-031 start during busy SHALL be ignored; abort and start together in IDLE: the pass starts.
REQ-032 Counter SHALL not wrap past DCNT-1; DCNT=1 gives a one-word pass.
REQ-033 SCRUB throughput SHALL be 2 cycles per clean word and 3 per fixed word when gnt=1 throughout.

Reset
REQ-034 Reset SHALL force:
- state IDLE and counter 0;
- busy, req, done, rd, wr, errcnt, erraddr, waddr, raddr, wdata all 0.
REQ-035 Reset mid-pass SHALL take effect immediately, asynchronously, with no partial write after deassertion.

Structure
REQ-036 Package mimm_scrub_pkg SHALL hold the state enum and the mode constants MODE_INIT=0 and MODE_SCRUB=1.
REQ-037 No sub-module SHALL be instantiated; the testbench SHALL connect the block to mimm_dpram.

Verification
REQ-038 INIT, DCNT=256, gnt=1: done at cycle 257 after start; all words read back 0; errcnt=0.
REQ-039 SCRUB with a parity bit flipped at addresses 5 and 200, fixen=0: errcnt=2, erraddr=5, done after 512 cycles, no wr seen.
REQ-040 Same as REQ-039 with fixen=1: two wr pulses at 5 and 200; a second SCRUB pass gives errcnt=0.
REQ-041 gnt toggled 50% at random during SCRUB: no rd or wr with gnt=0; result matches the gnt=1 run.
REQ-042 abort at word 100: busy low next cycle, no done; a new start runs a full pass from address 0.
REQ-043 reset asserted mid-INIT at word 40: all outputs 0 immediately, and words 40..255 are left unwritten.
